// File: rtl/m3_speedramp.sv
// Speed ramp stage ahead of the step calculator: turns speed commands and
// start/stop requests into a ramped per-slice period length.
module m3_speedramp #(
  parameter int unsigned LEN_MIN    = 1000,
  parameter int unsigned LEN_START  = 20000,
  parameter int unsigned LEN_MAX    = 40000,
  parameter int unsigned STEP_DELTA = 1000,
  parameter int unsigned RAMP_STEP  = 500
) (
  input  logic        clkI,
  input  logic        nRstI,
  input  logic        m3startI,
  input  logic        m3forceStopI,
  input  logic        m3speedINCi,
  input  logic        m3speedDECi,
  input  logic        nextCalc_1i,
  output logic [31:0] dstRoundLenO,
  output logic [31:0] targetLenO,
  output logic        m3startO,
  output logic        atSpeedO,
  output logic        stoppingO
);

  localparam int unsigned LW = 32;

  localparam logic [LW-1:0] C_MIN   = LW'(LEN_MIN);
  localparam logic [LW-1:0] C_START = LW'(LEN_START);
  localparam logic [LW-1:0] C_MAX   = LW'(LEN_MAX);
  localparam logic [LW-1:0] C_DELTA = LW'(STEP_DELTA);
  localparam logic [LW-1:0] C_RAMP  = LW'(RAMP_STEP);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [LW-1:0] r_len;
  logic [LW-1:0] r_tgt;
  logic [LW-1:0] w_len_nxt;
  logic [LW-1:0] w_tgt_nxt;
  logic [LW-1:0] w_ramp_dst;
  logic [LW-1:0] w_ramp_len;
  logic          r_start;
  logic          r_at_speed;
  logic          r_stopping;
  logic          w_start_nxt;
  logic          w_at_speed_nxt;
  logic          w_stopping_nxt;
  logic          r_inc_prev;
  logic          r_dec_prev;
  logic          w_inc_rise;
  logic          w_dec_rise;

  assign w_inc_rise = m3speedINCi & ~r_inc_prev;
  assign w_dec_rise = m3speedDECi & ~r_dec_prev;

  // Commanded target: one bounded step per isolated rise, frozen while stopping
  always_comb begin
    w_tgt_nxt = r_tgt;
    if (r_state != ST_STOP) begin
      if (w_inc_rise && !w_dec_rise) begin
        w_tgt_nxt = ((r_tgt - C_MIN) >= C_DELTA) ? (r_tgt - C_DELTA) : C_MIN;
      end else if (w_dec_rise && !w_inc_rise) begin
        w_tgt_nxt = ((C_MAX - r_tgt) >= C_DELTA) ? (r_tgt + C_DELTA) : C_MAX;
      end
    end
  end

  // One ramp step toward the running target, or toward the start length when stopping
  always_comb begin
    w_ramp_dst = ((r_state == ST_RUN) && !m3forceStopI) ? r_tgt : C_START;
    w_ramp_len = r_len;
    if (r_len > w_ramp_dst) begin
      w_ramp_len = ((r_len - w_ramp_dst) >= C_RAMP) ? (r_len - C_RAMP) : w_ramp_dst;
    end else if (r_len < w_ramp_dst) begin
      w_ramp_len = ((w_ramp_dst - r_len) >= C_RAMP) ? (r_len + C_RAMP) : w_ramp_dst;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_start_nxt = r_start;
    unique case (r_state)
      ST_IDLE: begin
        w_len_nxt   = C_START;
        w_start_nxt = 1'b0;
        if (m3startI && !m3forceStopI) begin
          w_state_nxt = ST_RUN;
          w_start_nxt = 1'b1;
        end
      end
      ST_RUN: begin
        w_start_nxt = 1'b1;
        if (!m3startI) begin
          w_state_nxt = ST_IDLE;
          w_len_nxt   = C_START;
          w_start_nxt = 1'b0;
        end else begin
          if (m3forceStopI) w_state_nxt = ST_STOP;
          if (nextCalc_1i)  w_len_nxt   = w_ramp_len;
        end
      end
      ST_STOP: begin
        w_start_nxt = 1'b1;
        if (!m3startI || (r_len == C_START)) begin
          w_state_nxt = ST_IDLE;
          w_len_nxt   = C_START;
          w_start_nxt = 1'b0;
        end else if (nextCalc_1i) begin
          w_len_nxt = w_ramp_len;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_len_nxt   = C_START;
        w_start_nxt = 1'b0;
      end
    endcase
    w_at_speed_nxt = (w_state_nxt == ST_RUN) && (w_len_nxt == w_tgt_nxt);
    w_stopping_nxt = (w_state_nxt == ST_STOP);
  end

  always_ff @(posedge clkI) begin
    if (!nRstI) begin
      r_state    <= ST_IDLE;
      r_len      <= C_START;
      r_tgt      <= C_START;
      r_start    <= 1'b0;
      r_at_speed <= 1'b0;
      r_stopping <= 1'b0;
      r_inc_prev <= 1'b0;
      r_dec_prev <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_len      <= w_len_nxt;
      r_tgt      <= w_tgt_nxt;
      r_start    <= w_start_nxt;
      r_at_speed <= w_at_speed_nxt;
      r_stopping <= w_stopping_nxt;
      r_inc_prev <= m3speedINCi;
      r_dec_prev <= m3speedDECi;
    end
  end

  assign dstRoundLenO = r_len;
  assign targetLenO   = r_tgt;
  assign m3startO     = r_start;
  assign atSpeedO     = r_at_speed;
  assign stoppingO    = r_stopping;

endmodule

// File: tb/tb_m3_speedramp.sv
// Scoreboard bench for m3_speedramp: instance 0 uses default lengths,
// instance 1 uses an odd start length and a 700 ramp step to reach clamp/partial-step corners.
module tb_m3_speedramp;

  logic        clk = 1'b0;
  logic [1:0]  rst_n = 2'b00;
  logic [1:0]  start = 2'b00;
  logic [1:0]  fstop = 2'b00;
  logic [1:0]  inc = 2'b00;
  logic [1:0]  dec = 2'b00;
  logic [1:0]  nc = 2'b00;
  logic [31:0] dst [2];
  logic [31:0] tgt [2];
  logic [1:0]  st_o;
  logic [1:0]  at_o;
  logic [1:0]  sp_o;

  typedef struct {
    int          id;
    logic [31:0] dst;
    logic [31:0] tgt;
    logic        st;
    logic        at;
    logic        sp;
  } exp_t;

  exp_t  exp_q  [$];
  string name_q [$];
  int    checks = 0;
  int    errors = 0;
  bit    done   = 1'b0;

  always #5 clk = ~clk;

  m3_speedramp u_dut0 (
    .clkI(clk), .nRstI(rst_n[0]), .m3startI(start[0]), .m3forceStopI(fstop[0]),
    .m3speedINCi(inc[0]), .m3speedDECi(dec[0]), .nextCalc_1i(nc[0]),
    .dstRoundLenO(dst[0]), .targetLenO(tgt[0]), .m3startO(st_o[0]),
    .atSpeedO(at_o[0]), .stoppingO(sp_o[0])
  );

  m3_speedramp #(.LEN_START(20500), .RAMP_STEP(700)) u_dut1 (
    .clkI(clk), .nRstI(rst_n[1]), .m3startI(start[1]), .m3forceStopI(fstop[1]),
    .m3speedINCi(inc[1]), .m3speedDECi(dec[1]), .nextCalc_1i(nc[1]),
    .dstRoundLenO(dst[1]), .targetLenO(tgt[1]), .m3startO(st_o[1]),
    .atSpeedO(at_o[1]), .stoppingO(sp_o[1])
  );

  // Monitor: drains pending expectations away from the active edge
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t  e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (dst[e.id] !== e.dst || tgt[e.id] !== e.tgt || st_o[e.id] !== e.st ||
          at_o[e.id] !== e.at || sp_o[e.id] !== e.sp) begin
        errors++;
        $display("FAIL %s (dut%0d): got dst=%0d tgt=%0d start=%b at=%b stop=%b, want dst=%0d tgt=%0d start=%b at=%b stop=%b",
                 n, e.id, dst[e.id], tgt[e.id], st_o[e.id], at_o[e.id], sp_o[e.id],
                 e.dst, e.tgt, e.st, e.at, e.sp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input int id, input string n, input int unsigned d,
                            input int unsigned t, input logic s, input logic a, input logic p);
    exp_t e;
    e.id = id; e.dst = 32'(d); e.tgt = 32'(t); e.st = s; e.at = a; e.sp = p;
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  task automatic pulse_inc(input int id);
    inc[id] = 1'b1; tick();
    inc[id] = 1'b0; tick();
  endtask

  task automatic pulse_dec(input int id);
    dec[id] = 1'b1; tick();
    dec[id] = 1'b0; tick();
  endtask

  task automatic pulse_nc(input int id);
    nc[id] = 1'b1; tick();
    nc[id] = 1'b0;
  endtask

  initial begin
    tick(); tick();
    rst_n = 2'b11;
    tick();
    expect_out(0, "reset", 20000, 20000, 0, 0, 0);
    expect_out(1, "reset", 20500, 20500, 0, 0, 0);

    // Three speed-ups in IDLE, then start and ramp down six steps
    repeat (3) pulse_inc(0);
    expect_out(0, "idle_inc3", 20000, 17000, 0, 0, 0);
    start[0] = 1'b1; tick();
    expect_out(0, "run_entry", 20000, 17000, 1, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      pulse_nc(0);
      expect_out(0, "ramp_step", 20000 - 500 * k, 17000, 1, (k == 6), 0);
    end

    // Simultaneous rises cancel; a held level gives exactly one step
    inc[0] = 1'b1; dec[0] = 1'b1; tick();
    inc[0] = 1'b0; dec[0] = 1'b0; tick();
    expect_out(0, "inc_dec_same", 17000, 17000, 1, 1, 0);
    inc[0] = 1'b1;
    repeat (100) tick();
    inc[0] = 1'b0; tick();
    expect_out(0, "inc_held", 17000, 16000, 1, 0, 0);
    pulse_dec(0);
    expect_out(0, "dec_back", 17000, 17000, 1, 1, 0);

    // Controlled stop ramps back to start length, commands ignored meanwhile
    fstop[0] = 1'b1; tick();
    expect_out(0, "stop_entry", 17000, 17000, 1, 0, 1);
    pulse_inc(0);
    expect_out(0, "stop_inc_ignored", 17000, 17000, 1, 0, 1);
    for (int k = 1; k <= 6; k++) begin
      pulse_nc(0);
      expect_out(0, "stop_ramp", 17000 + 500 * k, 17000, 1, 0, 1);
    end
    tick();
    expect_out(0, "stop_to_idle", 20000, 17000, 0, 0, 0);
    start[0] = 1'b0; fstop[0] = 1'b0; tick();

    // Start dropped mid-ramp
    start[0] = 1'b1; tick();
    expect_out(0, "restart", 20000, 17000, 1, 0, 0);
    repeat (3) pulse_nc(0);
    expect_out(0, "mid_ramp", 18500, 17000, 1, 0, 0);
    start[0] = 1'b0; tick();
    expect_out(0, "start_drop", 20000, 17000, 0, 0, 0);

    // Reset for one edge mid-RUN
    start[0] = 1'b1; tick();
    pulse_nc(0);
    expect_out(0, "pre_reset", 19500, 17000, 1, 0, 0);
    rst_n[0] = 1'b0; tick();
    rst_n[0] = 1'b1; start[0] = 1'b0;
    expect_out(0, "mid_reset", 20000, 20000, 0, 0, 0);
    tick();
    expect_out(0, "post_reset", 20000, 20000, 0, 0, 0);

    // Partial ramp step lands exactly on target (d=1000 -> 700 then 300)
    pulse_inc(1);
    start[1] = 1'b1; tick();
    expect_out(1, "run_entry", 20500, 19500, 1, 0, 0);
    pulse_nc(1);
    expect_out(1, "ramp_700", 19800, 19500, 1, 0, 0);
    pulse_nc(1);
    expect_out(1, "ramp_300", 19500, 19500, 1, 1, 0);
    start[1] = 1'b0; tick();
    expect_out(1, "idle", 20500, 19500, 0, 0, 0);

    // Lower clamp
    repeat (18) pulse_inc(1);
    expect_out(1, "tgt_1500", 20500, 1500, 0, 0, 0);
    pulse_inc(1);
    expect_out(1, "clamp_min", 20500, 1000, 0, 0, 0);
    pulse_inc(1);
    expect_out(1, "clamp_min_hold", 20500, 1000, 0, 0, 0);

    // Upper clamp
    rst_n[1] = 1'b0; tick();
    rst_n[1] = 1'b1; tick();
    repeat (19) pulse_dec(1);
    expect_out(1, "tgt_39500", 20500, 39500, 0, 0, 0);
    pulse_dec(1);
    expect_out(1, "clamp_max", 20500, 40000, 0, 0, 0);
    pulse_dec(1);
    expect_out(1, "clamp_max_hold", 20500, 40000, 0, 0, 0);

    tick(); tick();
    done = 1'b1;
  end

  initial begin
    fork
      wait (done);
      #200000;
    join_any
    disable fork;
    if (!done) begin
      errors++;
      $display("FAIL timeout: stimulus did not complete, pending=%0d, required done=1", exp_q.size());
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d unchecked expectations, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
